// File: rtl/bout_controller.sv
// Match-level sequencer for the fencing game: start handshake, countdown, fight window,
// touch tallying with inter-point pause, and winner declaration. All outputs registered.
module bout_controller #(
    parameter int TICK_CYCLES     = 74_250_000,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int PAUSE_TICKS     = 2,
    parameter int WIN_SCORE       = 5
) (
    input  logic       clk_pixel_in,
    input  logic       rst_n_in,
    input  logic       self_started_in,
    input  logic       opponent_started_in,
    input  logic       score_valid_in,
    input  logic       player_scored_in,
    input  logic       opponent_scored_in,
    input  logic       rematch_in,
    output logic [2:0] state_out,
    output logic [3:0] countdown_out,
    output logic       actions_enable_out,
    output logic       round_start_out,
    output logic       round_reset_out,
    output logic [3:0] player_score_out,
    output logic [3:0] opponent_score_out,
    output logic [1:0] winner_out
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_READY = 3'd1;
    localparam logic [2:0] S_COUNTDOWN  = 3'd2;
    localparam logic [2:0] S_FIGHT      = 3'd3;
    localparam logic [2:0] S_POINT      = 3'd4;
    localparam logic [2:0] S_MATCH_OVER = 3'd5;

    localparam int              TW         = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [3:0]      CD_INIT    = 4'(COUNTDOWN_TICKS);
    localparam logic [3:0]      PAUSE_INIT = 4'(PAUSE_TICKS);
    localparam logic [3:0]      WIN        = 4'(WIN_SCORE);

    // Score increment that never passes the winning tally.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic hit);
        logic [3:0] r;
        if (hit && (v < WIN)) begin
            r = v + 4'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    countdown_q, countdown_d;
    logic [3:0]    pause_q, pause_d;
    logic [3:0]    pscore_q, pscore_d;
    logic [3:0]    oscore_q, oscore_d;
    logic [1:0]    winner_q, winner_d;
    logic          enable_q, enable_d;
    logic          rstart_q, rstart_d;
    logic          rreset_q, rreset_d;

    logic          both_started_s;
    logic          tick_wrap_s;
    logic [TW-1:0] tick_inc_s;
    logic [3:0]    pscore_next_s;
    logic [3:0]    oscore_next_s;

    assign both_started_s = self_started_in & opponent_started_in;
    assign tick_wrap_s    = (tick_q == TICK_LAST);
    assign tick_inc_s     = tick_q + TW'(1);
    assign pscore_next_s  = sat_inc(pscore_q, player_scored_in);
    assign oscore_next_s  = sat_inc(oscore_q, opponent_scored_in);

    // Next-state and next-output logic for the match sequencer.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        countdown_d = countdown_q;
        pause_d     = pause_q;
        pscore_d    = pscore_q;
        oscore_d    = oscore_q;
        winner_d    = winner_q;
        enable_d    = enable_q;
        rstart_d    = 1'b0;
        rreset_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (self_started_in && opponent_started_in) begin
                    state_d     = S_COUNTDOWN;
                    countdown_d = CD_INIT;
                    tick_d      = '0;
                end else if (self_started_in) begin
                    state_d = S_WAIT_READY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_READY: begin
                if (both_started_s) begin
                    state_d     = S_COUNTDOWN;
                    countdown_d = CD_INIT;
                    tick_d      = '0;
                end else begin
                    state_d = S_WAIT_READY;
                end
            end
            S_COUNTDOWN: begin
                if (!both_started_s) begin
                    state_d     = S_WAIT_READY;
                    countdown_d = 4'd0;
                    tick_d      = '0;
                end else if (tick_wrap_s) begin
                    tick_d = '0;
                    // Last tick expiring opens the fight window; countdown reads 0 outside COUNTDOWN.
                    if (countdown_q == 4'd1) begin
                        state_d     = S_FIGHT;
                        countdown_d = 4'd0;
                        rstart_d    = 1'b1;
                        enable_d    = 1'b1;
                    end else begin
                        countdown_d = countdown_q - 4'd1;
                    end
                end else begin
                    tick_d = tick_inc_s;
                end
            end
            S_FIGHT: begin
                if (score_valid_in && (player_scored_in || opponent_scored_in)) begin
                    pscore_d = pscore_next_s;
                    oscore_d = oscore_next_s;
                    enable_d = 1'b0;
                    if ((pscore_next_s == WIN) || (oscore_next_s == WIN)) begin
                        state_d  = S_MATCH_OVER;
                        winner_d = {oscore_next_s == WIN, pscore_next_s == WIN};
                    end else begin
                        state_d  = S_POINT;
                        rreset_d = 1'b1;
                        tick_d   = '0;
                        pause_d  = PAUSE_INIT;
                    end
                end else begin
                    state_d = S_FIGHT;
                end
            end
            S_POINT: begin
                if (tick_wrap_s) begin
                    tick_d = '0;
                    if (pause_q == 4'd1) begin
                        state_d     = S_COUNTDOWN;
                        countdown_d = CD_INIT;
                    end else begin
                        pause_d = pause_q - 4'd1;
                    end
                end else begin
                    tick_d = tick_inc_s;
                end
            end
            S_MATCH_OVER: begin
                if (rematch_in) begin
                    pscore_d = 4'd0;
                    oscore_d = 4'd0;
                    winner_d = 2'b00;
                    if (both_started_s) begin
                        state_d     = S_COUNTDOWN;
                        countdown_d = CD_INIT;
                        tick_d      = '0;
                    end else begin
                        state_d = S_WAIT_READY;
                    end
                end else begin
                    state_d = S_MATCH_OVER;
                end
            end
            default: begin
                state_d     = S_IDLE;
                tick_d      = '0;
                countdown_d = 4'd0;
                pause_d     = 4'd0;
                pscore_d    = 4'd0;
                oscore_d    = 4'd0;
                winner_d    = 2'b00;
                enable_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            countdown_q <= 4'd0;
            pause_q     <= 4'd0;
            pscore_q    <= 4'd0;
            oscore_q    <= 4'd0;
            winner_q    <= 2'b00;
            enable_q    <= 1'b0;
            rstart_q    <= 1'b0;
            rreset_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            countdown_q <= countdown_d;
            pause_q     <= pause_d;
            pscore_q    <= pscore_d;
            oscore_q    <= oscore_d;
            winner_q    <= winner_d;
            enable_q    <= enable_d;
            rstart_q    <= rstart_d;
            rreset_q    <= rreset_d;
        end
    end

    assign state_out          = state_q;
    assign countdown_out      = countdown_q;
    assign actions_enable_out = enable_q;
    assign round_start_out    = rstart_q;
    assign round_reset_out    = rreset_q;
    assign player_score_out   = pscore_q;
    assign opponent_score_out = oscore_q;
    assign winner_out         = winner_q;

endmodule

// File: tb/tb_bout_controller.sv
// Bench for bout_controller: directed match scenarios followed by randomized play,
// all compared each cycle against a cycle-count based behavioural model.
module tb_bout_controller;

    localparam int T = 4;
    localparam int C = 3;
    localparam int P = 2;
    localparam int W = 2;

    localparam int ST_IDLE  = 0;
    localparam int ST_WAIT  = 1;
    localparam int ST_CD    = 2;
    localparam int ST_FIGHT = 3;
    localparam int ST_POINT = 4;
    localparam int ST_MATCH = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       self_st = 1'b0;
    logic       opp_st = 1'b0;
    logic       sv = 1'b0;
    logic       ps = 1'b0;
    logic       os = 1'b0;
    logic       rematch = 1'b0;
    logic [2:0] state_out;
    logic [3:0] countdown_out;
    logic       actions_enable_out;
    logic       round_start_out;
    logic       round_reset_out;
    logic [3:0] player_score_out;
    logic [3:0] opponent_score_out;
    logic [1:0] winner_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase plus cycles elapsed in the timed phases.
    int m_state, m_el, m_ps, m_os, m_win, m_rs, m_rr;

    bout_controller #(
        .TICK_CYCLES(T), .COUNTDOWN_TICKS(C), .PAUSE_TICKS(P), .WIN_SCORE(W)
    ) dut (
        .clk_pixel_in        (clk),
        .rst_n_in            (rst_n),
        .self_started_in     (self_st),
        .opponent_started_in (opp_st),
        .score_valid_in      (sv),
        .player_scored_in    (ps),
        .opponent_scored_in  (os),
        .rematch_in          (rematch),
        .state_out           (state_out),
        .countdown_out       (countdown_out),
        .actions_enable_out  (actions_enable_out),
        .round_start_out     (round_start_out),
        .round_reset_out     (round_reset_out),
        .player_score_out    (player_score_out),
        .opponent_score_out  (opponent_score_out),
        .winner_out          (winner_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_el = 0; m_ps = 0; m_os = 0; m_win = 0; m_rs = 0; m_rr = 0;
    endtask

    task automatic model_edge();
        m_rs = 0;
        m_rr = 0;
        case (m_state)
            ST_IDLE: begin
                if (self_st && opp_st) begin m_state = ST_CD; m_el = 0; end
                else if (self_st) m_state = ST_WAIT;
            end
            ST_WAIT: if (self_st && opp_st) begin m_state = ST_CD; m_el = 0; end
            ST_CD: begin
                if (!(self_st && opp_st)) m_state = ST_WAIT;
                else begin
                    m_el++;
                    if (m_el == C * T) begin m_state = ST_FIGHT; m_rs = 1; end
                end
            end
            ST_FIGHT: begin
                if (sv && (ps || os)) begin
                    if (ps && m_ps < W) m_ps++;
                    if (os && m_os < W) m_os++;
                    if (m_ps == W || m_os == W) begin
                        m_state = ST_MATCH;
                        m_win = (m_os == W ? 2 : 0) + (m_ps == W ? 1 : 0);
                    end else begin
                        m_state = ST_POINT; m_el = 0; m_rr = 1;
                    end
                end
            end
            ST_POINT: begin
                m_el++;
                if (m_el == P * T) begin m_state = ST_CD; m_el = 0; end
            end
            ST_MATCH: begin
                if (rematch) begin
                    m_ps = 0; m_os = 0; m_win = 0;
                    if (self_st && opp_st) begin m_state = ST_CD; m_el = 0; end
                    else m_state = ST_WAIT;
                end
            end
            default: m_state = ST_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("state", state_out, m_state);
        chk("countdown", countdown_out, (m_state == ST_CD) ? (C - m_el / T) : 0);
        chk("actions_enable", actions_enable_out, (m_state == ST_FIGHT) ? 1 : 0);
        chk("round_start", round_start_out, m_rs);
        chk("round_reset", round_reset_out, m_rr);
        chk("player_score", player_score_out, m_ps);
        chk("opponent_score", opponent_score_out, m_os);
        chk("winner", winner_out, m_win);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_strobes();
        sv = 1'b0; ps = 1'b0; os = 1'b0; rematch = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (m_state != target && n < budget) begin
            step();
            n++;
        end
        chk(tag, state_out, target);
    endtask

    // Asynchronous reset asserted between edges, released just after an edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        #1 compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        chk("reset_state", state_out, ST_IDLE);
        rst_n = 1'b1;
        step();

        // Start sequencing and countdown length
        self_st = 1'b1; step();
        chk("wait_ready", state_out, ST_WAIT);
        repeat (4) step();
        opp_st = 1'b1; step();
        n = 0;
        while (state_out == 3'd2 && n < 50) begin n++; step(); end
        chk("countdown_len", n, 12);
        chk("round_start_pulse", round_start_out, 1);
        step();
        chk("round_start_single", round_start_out, 0);

        // Single touch, pause length, strobes ignored in POINT and COUNTDOWN
        sv = 1'b1; ps = 1'b1; step(); clear_strobes();
        chk("touch_player_score", player_score_out, 1);
        chk("touch_round_reset", round_reset_out, 1);
        n = 0;
        while (state_out == 3'd4 && n < 50) begin
            n++;
            if (n == 3) begin sv = 1'b1; ps = 1'b1; os = 1'b1; end
            else clear_strobes();
            step();
        end
        clear_strobes();
        chk("point_len", n, 8);
        chk("cd_after_point", countdown_out, 3);
        sv = 1'b1; ps = 1'b1; os = 1'b1; step(); clear_strobes();
        chk("ignored_p", player_score_out, 1);
        chk("ignored_o", opponent_score_out, 0);

        // Opponent touch to 1-1, then double touch ends the match as a tie
        run_until(ST_FIGHT, 40, "reach_fight2");
        sv = 1'b1; os = 1'b1; step(); clear_strobes();
        chk("one_all_o", opponent_score_out, 1);
        run_until(ST_FIGHT, 40, "reach_fight3");
        sv = 1'b1; ps = 1'b1; os = 1'b1; step();
        chk("double_state", state_out, ST_MATCH);
        chk("double_winner", winner_out, 3);
        step(); clear_strobes();
        chk("post_match_p", player_score_out, 2);
        chk("post_match_o", opponent_score_out, 2);

        // Rematch with both started, then a player win and a rematch without opponent
        rematch = 1'b1; step(); clear_strobes();
        chk("rematch_state", state_out, ST_CD);
        chk("rematch_score", player_score_out, 0);
        chk("rematch_winner", winner_out, 0);
        repeat (2) begin
            run_until(ST_FIGHT, 40, "reach_fight_p");
            sv = 1'b1; ps = 1'b1; step(); clear_strobes();
        end
        chk("player_win", winner_out, 1);
        opp_st = 1'b0;
        rematch = 1'b1; step(); clear_strobes();
        chk("rematch_wait", state_out, ST_WAIT);

        // Dropout during countdown
        opp_st = 1'b1; step();
        chk("dropout_cd", state_out, ST_CD);
        repeat (3) step();
        opp_st = 1'b0; step();
        chk("dropout_state", state_out, ST_WAIT);
        chk("dropout_countdown", countdown_out, 0);

        // Reset with tick counter at 2 in countdown
        opp_st = 1'b1; step();
        repeat (2) step();
        do_reset();
        chk("midreset_state", state_out, ST_IDLE);
        chk("midreset_countdown", countdown_out, 0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            self_st = self_st ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 4) == 0);
            opp_st  = opp_st  ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 4) == 0);
            sv      = ($urandom_range(0, 2) == 0);
            ps      = 1'($urandom_range(0, 1));
            os      = 1'($urandom_range(0, 1));
            rematch = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
